// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request scheduler: FSM encoding, widths, fixed-point scale.
// Latency: none (constants and a pure helper function only).
// Backpressure: none.
package cordic_pkg;

    // Default operand/result width; values are signed 2.6 fixed point.
    localparam int W_DEFAULT = 8;

    // 2.6 fixed point: 1.0 is represented as 64.
    localparam int FX_SCALE = 64;

    // Scheduler FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Round-robin successor: the requester after id, wrapping at nreq.
    function automatic logic [2:0] rr_next(input logic [2:0] id, input int nreq);
        return (int'(id) == nreq - 1) ? 3'd0 : id + 3'd1;
    endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used.
module cordic_rr_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_id,
    output logic            gnt_any
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] idx;

    // Scan requesters starting at ptr; the first set bit wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one CORDIC engine among NREQ requesters, one operation in flight, with engine timeout.
// Latency: accept -> eng_start 2 cycles; accept -> rsp_valid 3 cycles + engine latency.
// Backpressure: response held until rsp_ready; no new request is granted while one is outstanding.
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEFAULT,
    parameter int TMO  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    input  logic [NREQ*W-1:0] req_angle,
    output logic              eng_start,
    output logic [W-1:0]      eng_xin,
    output logic [W-1:0]      eng_yin,
    output logic [W-1:0]      eng_angle,
    input  logic              eng_done,
    input  logic [W-1:0]      eng_sine,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_id,
    output logic [W-1:0]      rsp_sine,
    output logic              rsp_err
);

    localparam int CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    id_q, id_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d, a_q, a_d;
    logic [W-1:0]  sine_q, sine_d;
    logic          err_q, err_d;
    logic          start_q, start_d;

    logic [NREQ-1:0] gnt;
    logic [2:0]      gnt_id;
    logic            gnt_any;
    logic [W-1:0]    x_sel, y_sel, a_sel;

    cordic_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        a_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                x_sel = req_x[i*W +: W];
                y_sel = req_y[i*W +: W];
                a_sel = req_angle[i*W +: W];
            end
        end
    end

    // Scheduler FSM: accept, start engine, wait with timeout, hold response.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        a_d     = a_q;
        sine_d  = sine_q;
        err_d   = err_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    id_d    = gnt_id;
                    x_d     = x_sel;
                    y_d     = y_sel;
                    a_d     = a_sel;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (eng_done) begin
                    sine_d  = eng_sine;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TMO)) begin
                    sine_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    ptr_d   = rr_next(id_q, NREQ);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            sine_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            a_q     <= a_d;
            sine_q  <= sine_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    // Grant is combinational from req_valid, so gate it with rst_n to keep it low in reset.
    assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : '0;
    assign eng_start = start_q;
    assign eng_xin   = x_q;
    assign eng_yin   = y_q;
    assign eng_angle = a_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_sine  = sine_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler with a behavioural engine of programmable latency.
// Latency: n/a (testbench).
// Backpressure: rsp_ready driven by the stimulus process.
module tb_cordic_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int TMO  = 31;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*W-1:0]      req_x, req_y, req_angle;
    logic                   eng_start;
    logic signed [W-1:0]    eng_xin, eng_yin, eng_angle;
    logic                   eng_done;
    logic signed [W-1:0]    eng_sine;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [2:0]             rsp_id;
    logic signed [W-1:0]    rsp_sine;
    logic                   rsp_err;

    cordic_scheduler #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_angle (req_angle),
        .eng_start (eng_start),
        .eng_xin   (eng_xin),
        .eng_yin   (eng_yin),
        .eng_angle (eng_angle),
        .eng_done  (eng_done),
        .eng_sine  (eng_sine),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sine  (rsp_sine),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        int id;
        int sine;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_rsp  = 0;
    int n_gnt  = 0;
    int t_acc  = 0;
    int t_start = 0;
    int t_rsp  = 0;
    int eng_lat = 9;
    int mon_g;
    logic signed [W-1:0] eng_res;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed sin(angle) in 2.6 fixed point for the angles used below.
    function automatic logic signed [7:0] sine_of(input logic signed [7:0] a);
        case (a)
            8'sd50:   return 8'sd45;   // sin(0.78125)  = 0.704
            8'sd25:   return 8'sd24;   // sin(0.390625) = 0.381
            8'sd100:  return 8'sd64;   // sin(1.5625)   = 1.000
            -8'sd50:  return -8'sd45;
            default:  return 8'sd0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input int id, input int sine, input int err);
        exp_t e;
        e.id = id;
        e.sine = sine;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Engine model: eng_done eng_lat cycles after the eng_start cycle; never if eng_lat < 0.
    initial begin
        eng_done = 1'b0;
        eng_sine = '0;
        forever begin
            @(posedge clk); #1;
            if (eng_start && eng_lat >= 0) begin
                eng_res = sine_of(eng_angle);
                repeat (eng_lat) @(posedge clk);
                #1;
                eng_done = 1'b1;
                eng_sine = eng_res;
                @(posedge clk); #1;
                eng_done = 1'b0;
                eng_sine = '0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every completed handshake.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            t_rsp = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: id %0d sine %0d err %0d with none expected", rsp_id, rsp_sine, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_id", int'(rsp_id), e.id);
                check("rsp_sine", int'(rsp_sine), e.sine);
                check("rsp_err", int'(rsp_err), e.err);
            end
        end
    end

    // Grant monitor: one-hot, only to a valid requester, in the expected order.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            n_gnt++;
            t_acc = cyc;
            mon_g = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_g = i;
            check("gnt_onehot", $countones(req_ready), 1);
            check("gnt_subset", int'(req_ready & ~req_valid), 0);
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gnt_unexpected: granted %0d with none expected", mon_g);
            end else begin
                check("gnt_order", mon_g, gnt_q.pop_front());
            end
        end
    end

    always @(negedge clk) if (eng_start) t_start = cyc;

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, int'(req_ready), 0);
        check({tag, "_eng_start"}, int'(eng_start), 0);
        check({tag, "_eng_xin"},   int'(eng_xin), 0);
        check({tag, "_eng_yin"},   int'(eng_yin), 0);
        check({tag, "_eng_angle"}, int'(eng_angle), 0);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_rsp_id"},    int'(rsp_id), 0);
        check({tag, "_rsp_sine"},  int'(rsp_sine), 0);
        check({tag, "_rsp_err"},   int'(rsp_err), 0);
    endtask

    task automatic set_ops(input int i, input int x, input int y, input int a);
        req_x[i*W +: W]     = W'(x);
        req_y[i*W +: W]     = W'(y);
        req_angle[i*W +: W] = W'(a);
    endtask

    // Raise one request, hold until granted, then drop it.
    task automatic request(input int i, input int x, input int y, input int a);
        int k;
        @(posedge clk); #1;
        set_ops(i, x, y, a);
        req_valid[i] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req_ready[i] && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: requester %0d never granted", i);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string what);
        int k;
        k = 0;
        while (n_rsp < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (n_rsp < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d responses, needed %0d", what, n_rsp, target);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int k;
        rst_n     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_angle = '0;
        rsp_ready = 1'b1;

        // Reset: outputs forced low even with all requesters asking.
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_angle = {4{8'sd50}};
        req_x     = {4{8'sd33}};
        #1;
        check_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst_clk");
        req_valid = '0;
        req_x     = '0;
        req_angle = '0;
        rst_n     = 1'b1;

        // Single request, engine latency 9.
        eng_lat = 9;
        base = n_rsp;
        gnt_q.push_back(0);
        expect_rsp(0, 45, 0);
        request(0, 40, 10, 50);
        wait_rsp(base + 1, "single");
        check("single_start_lat", t_start - t_acc, 2);
        check("single_rsp_lat", t_rsp - t_acc, 12);
        check("single_eng_xin", int'(eng_xin), 40);
        check("single_eng_yin", int'(eng_yin), 10);
        check("single_eng_angle", int'(eng_angle), 50);

        // Fairness: all four continuously valid after a fresh reset.
        do_reset();
        eng_lat = 3;
        base = n_rsp;
        set_ops(0, 1, 2, 50);
        set_ops(1, 3, 4, 25);
        set_ops(2, 5, 6, 100);
        set_ops(3, 7, 8, -50);
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2);
        gnt_q.push_back(3); gnt_q.push_back(0);
        expect_rsp(0, 45, 0);
        expect_rsp(1, 24, 0);
        expect_rsp(2, 64, 0);
        expect_rsp(3, -45, 0);
        expect_rsp(0, 45, 0);
        k = n_gnt;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        while (n_gnt < k + 5 && cyc < 20000) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(base + 5, "fair");

        // Engine never finishes: timeout after TMO+1 WAIT cycles.
        eng_lat = -1;
        base = n_rsp;
        gnt_q.push_back(2);
        expect_rsp(2, 0, 1);
        request(2, 9, 9, 100);
        wait_rsp(base + 1, "tmo");
        check("tmo_wait_cycles", t_rsp - t_start, TMO + 1);

        // Backpressure: response held for 5 cycles with another request pending.
        eng_lat = 4;
        rsp_ready = 1'b0;
        base = n_rsp;
        gnt_q.push_back(3);
        expect_rsp(3, 24, 0);
        request(3, 11, 12, 25);
        k = 0;
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("bp_rsp_valid_seen", int'(rsp_valid), 1);
        @(posedge clk); #1;
        set_ops(1, 13, 14, -50);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(rsp_valid), 1);
            check("bp_hold_id", int'(rsp_id), 3);
            check("bp_hold_sine", int'(rsp_sine), 24);
            check("bp_hold_err", int'(rsp_err), 0);
            check("bp_hold_ready", int'(req_ready), 0);
        end
        gnt_q.push_back(1);
        expect_rsp(1, -45, 0);
        k = n_gnt;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_rsp(base + 1, "bp_first");
        base = t_rsp;
        while (n_gnt == k && cyc < 20000) @(negedge clk);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("bp_accept_after_hs", t_acc - base, 1);
        wait_rsp(n_rsp + 1, "bp_second");

        // Reset during WAIT: outputs drop at once, late eng_done is ignored.
        eng_lat = 20;
        gnt_q.push_back(0);
        request(0, 21, 22, 50);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("wait_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = n_rsp;
        repeat (40) @(negedge clk);
        check("no_rsp_after_reset", n_rsp, base);
        check("idle_after_reset", int'(rsp_valid), 0);

        // eng_done exactly when the counter reaches TMO: success.
        eng_lat = TMO;
        base = n_rsp;
        gnt_q.push_back(1);
        expect_rsp(1, 45, 0);
        request(1, 31, 32, 50);
        wait_rsp(base + 1, "done_at_tmo");
        check("done_at_tmo_cycles", t_rsp - t_start, TMO + 1);

        // eng_done one cycle too late: timeout, late pulse ignored.
        eng_lat = TMO + 1;
        base = n_rsp;
        gnt_q.push_back(2);
        expect_rsp(2, 0, 1);
        request(2, 41, 42, 25);
        wait_rsp(base + 1, "done_late");
        check("done_late_cycles", t_rsp - t_start, TMO + 1);
        repeat (10) @(negedge clk);
        check("done_late_single_rsp", n_rsp, base + 1);

        check("exp_q_drained", exp_q.size(), 0);
        check("gnt_q_drained", gnt_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one CORDIC engine, range 2..8.
REQ-002 Parameter W, default 8: signed operand/result width in 2.6 fixed point.
REQ-003 Parameter TMO, default 31: maximum cycles to wait for eng_done before aborting.
REQ-004 Ports: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NREQ  per-requester operation request.
REQ-008 req_ready  out  NREQ  one-hot grant, asserted in the cycle the request is accepted.
REQ-009 req_x, req_y, req_angle  in  NREQ*W each  operands; requester i occupies bits [i*W +: W].
REQ-010 eng_start  out  1  single-cycle engine start pulse.
REQ-011 eng_xin, eng_yin, eng_angle  out  W each  operands to the engine, held stable from start through done.
REQ-012 eng_done  in  1  single-cycle engine completion pulse.
REQ-013 eng_sine  in  W  engine result, valid with eng_done.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_ready  in  1  response consumer ready.
REQ-016 rsp_id  out  3  index of the requester that owns the response.
REQ-017 rsp_sine  out  W  result; 0 on timeout.
REQ-018 rsp_err  out  1  1 = engine timed out.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: when any req_valid bit is 1, grant the first set bit at or after ptr (round-robin, wrapping), pulse req_ready[grant], latch operands and id, go to ISSUE; otherwise stay.
REQ-021 A request is accepted only when req_valid[i] and req_ready[i] are both 1; req_ready is 0 in every state except the IDLE accept cycle.
REQ-022 ISSUE: assert eng_start for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-023 WAIT: on eng_done, latch eng_sine, set rsp_err=0, go to RESP; otherwise increment the counter.
REQ-024 WAIT timeout: when the counter reaches TMO without eng_done, set rsp_sine=0 and rsp_err=1, go to RESP.
REQ-025 eng_done arriving in the same cycle the counter reaches TMO is treated as success.
REQ-026 eng_done outside WAIT is ignored.
REQ-027 RESP: hold rsp_valid=1 with stable rsp_id, rsp_sine and rsp_err until rsp_ready=1, then go to IDLE.
REQ-028 On response completion, ptr becomes (granted id + 1) mod NREQ.
REQ-029 Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
REQ-030 Only one operation is in flight at a time; minimum request-to-response latency is 3 cycles plus the engine latency.
REQ-031 eng_x/y/angle drive the latched operands and do not change in ISSUE or WAIT.

Reset
REQ-032 While rst_n=0: state=IDLE, ptr=0, counter=0, latched operands=0.
REQ-033 While rst_n=0 all outputs are 0: req_ready, eng_start, eng_xin/yin/angle, rsp_valid, rsp_id, rsp_sine, rsp_err.
REQ-034 Reset asserted mid-operation abandons the operation; no response is issued after reset is released.
REQ-035 Reset release is synchronized by the integrating design; the block samples nothing in the cycle rst_n rises.

Structure
REQ-036 A shared package cordic_pkg holds the FSM state encoding, the default W, and the 2.6 fixed-point scale constant (64).
REQ-037 One sub-module, cordic_rr_arbiter (NREQ-bit request vector plus ptr, producing a one-hot grant combinationally), is instantiated; the FSM stays in cordic_scheduler.

Verification
REQ-038 Single request: req_valid=4'b0001 with angle=8'sd50 (~0.78 rad) and engine model latency 9 -> eng_start 2 cycles after accept; rsp_id=0, rsp_sine=eng_sine, rsp_err=0.
REQ-039 All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; no requester granted twice before all others.
REQ-040 Engine model never asserts eng_done -> rsp_valid rises after TMO+1 WAIT cycles with rsp_err=1 and rsp_sine=0.
REQ-041 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready stays 0, and a new request is accepted only after the handshake.
REQ-042 rst_n pulsed low during WAIT -> all outputs 0 immediately (asynchronous); a late eng_done after release produces no response.
REQ-043 eng_done in the cycle the counter equals TMO -> rsp_err=0 and the engine result is returned.
